oddr_tx_sched: RTL and testbench
================================

ODDR_TX_SCHED -- requirements
Module: oddr_tx_sched

Interface
REQ-001 SHALL have parameter IDLE_PAT, default 2'b00, {d1,d2} value driven while idle.
REQ-002 SHALL have parameter TRAIN_LEN, default 16, number of cycles in one training burst; legal range 2..255.
REQ-003 SHALL have port C  input  1  clock; all state updates on posedge C.
REQ-004 SHALL have port R  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port in_valid  input  1  upstream word valid.
REQ-006 SHALL have port in_data  input  4  upstream nibble; bit 3 is transmitted first.
REQ-007 SHALL have port in_ready  output  1  FIFO can accept a word; high when occupancy < 4.
REQ-008 SHALL have port train_req  input  1  request one training burst; level or pulse.
REQ-009 SHALL have port train_busy  output  1  training pending or in progress.
REQ-010 SHALL have port d1  output  1  rising-edge data for the DDR output register.
REQ-011 SHALL have port d2  output  1  falling-edge data for the DDR output register.
REQ-012 SHALL have port ce  output  1  clock enable for the DDR output register.
REQ-013 SHALL have port level  output  3  FIFO occupancy, 0..4.
REQ-014 SHALL have port words_sent  output  8  count of words serialized, wraps 255->0.

Function
REQ-015 SHALL buffer words in a 4-entry FIFO.
- Push on posedge when in_valid && in_ready.
- Pop when the scheduler enters SEND_HI.
- Push and pop in the same cycle SHALL both take effect, leaving level unchanged.
- in_ready SHALL derive from registered occupancy only; a push on a full FIFO is impossible by construction.
REQ-016 SHALL implement states IDLE, TRAIN, SEND_HI, SEND_LO.
- The state register names what d1/d2 currently show.
- d1, d2 and ce are registered outputs.
REQ-017 Output per state:
- IDLE: {d1,d2} = IDLE_PAT.
- TRAIN: d1 = 1, d2 = 0.
- SEND_HI: {d1,d2} = word[3:2].
- SEND_LO: {d1,d2} = word[1:0].
REQ-018 Decision point, evaluated at the posedge leaving IDLE, leaving SEND_LO, or ending TRAIN, first match wins:
- training pending -> TRAIN;
- FIFO non-empty -> SEND_HI with pop;
- otherwise -> IDLE.
REQ-019 SEND_HI SHALL always go to SEND_LO on the next posedge; training SHALL never split a word.
REQ-020 Training pending flag:
- set on any posedge where train_req = 1 and state != TRAIN;
- cleared on entry to TRAIN;
- train_req while in TRAIN SHALL be ignored.
REQ-021 TRAIN SHALL last exactly TRAIN_LEN cycles, using a down-counter loaded with TRAIN_LEN-1 on entry; the decision point applies when the counter reaches 0.
REQ-022 Back-to-back words SHALL stream with no gap: SEND_LO -> SEND_HI when the FIFO is non-empty.
REQ-023 Latency: a word pushed at posedge k SHALL appear on d1/d2 after posedge k+1 at the earliest, when the scheduler is at a decision point in cycle k+1.
REQ-024 words_sent SHALL increment on each SEND_LO -> any transition.
REQ-025 train_busy SHALL = pending || (state == TRAIN).
REQ-026 ce SHALL be 1 in every state after reset release.

Reset
REQ-027 While R = 1, asynchronously and independent of C:
- state = IDLE; FIFO empty; level = 0; in_ready = 0;
- pending = 0; train counter = 0; words_sent = 0;
- {d1,d2} = IDLE_PAT; ce = 0; train_busy = 0.
REQ-028 in_ready SHALL go to 1 and ce to 1 at the first posedge after R deasserts.
REQ-029 A word mid-transmission when R asserts SHALL be discarded, not resumed.

Verification
REQ-030 Single word: push 4'b1011 in idle -> {d1,d2} = 10 for one cycle, then 11, then IDLE_PAT; words_sent = 1.
REQ-031 Streaming: push 4'hA, 4'h5, 4'hF back-to-back -> d1/d2 sequence 10,10,01,01,11,11 with no idle gap; level peaks <= 2; in_ready stays 1.
REQ-032 Full FIFO: hold the scheduler in TRAIN while pushing 5 words -> in_ready = 0 after the 4th push, 5th not accepted; after training, 4 words emitted in order.
REQ-033 Training: pulse train_req during SEND_HI of 4'hC -> 11, 00 completes, then exactly TRAIN_LEN cycles of d1 = 1, d2 = 0; train_busy falls at the last TRAIN cycle's exit.
REQ-034 Reset mid-word: assert R during SEND_HI with 2 words queued -> {d1,d2} = IDLE_PAT and ce = 0 immediately, without a clock edge; level = 0; after release, no queued data is emitted.

Source files
------------

// File: rtl/oddr_tx_sched.sv
// ---------------------------------------------------------------------------
// oddr_tx_sched
//
// Serializes 4-bit words onto a 2-bit DDR output register interface
// (d1 = rising-edge bit, d2 = falling-edge bit). Words are buffered in a
// 4-entry FIFO and sent as two halves, upper pair first. On request the
// scheduler inserts a training burst of TRAIN_LEN cycles showing d1=1, d2=0,
// but only at word boundaries.
//
// Parameters
//   IDLE_PAT   {d1,d2} value shown while idle
//   TRAIN_LEN  cycles per training burst (2..255)
//
// Ports
//   C           clock, all state updates on posedge
//   R           asynchronous active-high reset
//   in_valid    upstream word valid
//   in_data     upstream nibble, bit 3 transmitted first
//   in_ready    FIFO can accept a word (occupancy < 4)
//   train_req   request one training burst (level or pulse)
//   train_busy  training pending or in progress
//   d1, d2      rising / falling edge data for the DDR register
//   ce          clock enable for the DDR register
//   level       FIFO occupancy 0..4
//   words_sent  words serialized so far, wraps at 256
// ---------------------------------------------------------------------------
module oddr_tx_sched #(
    parameter logic [1:0] IDLE_PAT  = 2'b00,
    parameter int         TRAIN_LEN = 16
) (
    input  logic       C,
    input  logic       R,
    input  logic       in_valid,
    input  logic [3:0] in_data,
    output logic       in_ready,
    input  logic       train_req,
    output logic       train_busy,
    output logic       d1,
    output logic       d2,
    output logic       ce,
    output logic [2:0] level,
    output logic [7:0] words_sent
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        TRAIN   = 2'd1,
        SEND_HI = 2'd2,
        SEND_LO = 2'd3
    } state_t;

    state_t      state;
    state_t      next_state;
    logic [3:0]  fifo_mem [4];
    logic [1:0]  rd_ptr;
    logic [1:0]  wr_ptr;
    logic [2:0]  count;
    logic [1:0]  lo_bits;
    logic        pending;
    logic [7:0]  train_cnt;
    logic [7:0]  words;
    logic        run;
    logic [1:0]  d_q;
    logic [1:0]  d_next;
    logic        ce_q;
    logic        push;
    logic        pop;
    logic        at_decision;
    logic        load_train;

    // run goes high on the first clock after reset so that in_ready stays low
    // while reset is held, yet in_ready is still a function of registered
    // occupancy only.
    assign in_ready   = run && (count < 3'd4);
    assign push       = in_valid && in_ready;
    assign level      = count;
    assign words_sent = words;
    assign train_busy = pending || (state == TRAIN);
    assign d1         = d_q[1];
    assign d2         = d_q[0];
    assign ce         = ce_q;

    // A decision is taken when leaving IDLE, leaving SEND_LO, or on the last
    // cycle of a training burst. SEND_HI is never a decision point, which is
    // what keeps training from splitting a word.
    assign at_decision = (state == IDLE) || (state == SEND_LO) ||
                         ((state == TRAIN) && (train_cnt == 8'd0));
    assign load_train  = at_decision && pending;

    // State register together with the FIFO bookkeeping and registered
    // outputs. Everything here is cleared asynchronously so a word in flight
    // is dropped rather than resumed.
    always_ff @(posedge C or posedge R) begin
        if (R) begin
            state     <= IDLE;
            rd_ptr    <= 2'd0;
            wr_ptr    <= 2'd0;
            count     <= 3'd0;
            lo_bits   <= 2'd0;
            pending   <= 1'b0;
            train_cnt <= 8'd0;
            words     <= 8'd0;
            run       <= 1'b0;
            d_q       <= IDLE_PAT;
            ce_q      <= 1'b0;
        end else begin
            state <= next_state;
            run   <= 1'b1;
            ce_q  <= 1'b1;
            d_q   <= d_next;

            if (push) begin
                wr_ptr <= wr_ptr + 2'd1;
            end
            if (pop) begin
                rd_ptr  <= rd_ptr + 2'd1;
                lo_bits <= fifo_mem[rd_ptr][1:0];
            end
            case ({push, pop})
                2'b10:   count <= count + 3'd1;
                2'b01:   count <= count - 3'd1;
                default: count <= count;
            endcase

            // Entering TRAIN clears the request; requests seen during TRAIN
            // are dropped.
            if (load_train) begin
                pending <= 1'b0;
            end else if (train_req && (state != TRAIN)) begin
                pending <= 1'b1;
            end

            if (load_train) begin
                train_cnt <= 8'(TRAIN_LEN - 1);
            end else if ((state == TRAIN) && (train_cnt != 8'd0)) begin
                train_cnt <= train_cnt - 8'd1;
            end

            if (state == SEND_LO) begin
                words <= words + 8'd1;
            end
        end
    end

    // FIFO storage carries no reset; emptiness is tracked by the pointers.
    always_ff @(posedge C) begin
        if (push) begin
            fifo_mem[wr_ptr] <= in_data;
        end
    end

    // Next-state logic: training first, then data, otherwise idle.
    always_comb begin
        next_state = state;
        pop        = 1'b0;
        if (state == SEND_HI) begin
            next_state = SEND_LO;
        end else if (at_decision) begin
            if (pending) begin
                next_state = TRAIN;
            end else if (count != 3'd0) begin
                next_state = SEND_HI;
                pop        = 1'b1;
            end else begin
                next_state = IDLE;
            end
        end
    end

    // Output pattern for the state about to be entered; registered above so
    // d1/d2 always match the state register.
    always_comb begin
        d_next = IDLE_PAT;
        case (next_state)
            IDLE:    d_next = IDLE_PAT;
            TRAIN:   d_next = 2'b10;
            SEND_HI: d_next = fifo_mem[rd_ptr][3:2];
            SEND_LO: d_next = lo_bits;
            default: d_next = IDLE_PAT;
        endcase
    end

endmodule

// File: tb/tb_oddr_tx_sched.sv
module tb_oddr_tx_sched;

    localparam int         TL = 6;
    localparam logic [1:0] IP = 2'b01;

    logic       C;
    logic       R;
    logic       in_valid;
    logic [3:0] in_data;
    logic       in_ready;
    logic       train_req;
    logic       train_busy;
    logic       d1;
    logic       d2;
    logic       ce;
    logic [2:0] level;
    logic [7:0] words_sent;

    int total = 0;
    int bad   = 0;

    oddr_tx_sched #(.IDLE_PAT(IP), .TRAIN_LEN(TL)) dut (
        .C(C), .R(R), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .train_req(train_req), .train_busy(train_busy),
        .d1(d1), .d2(d2), .ce(ce), .level(level), .words_sent(words_sent)
    );

    initial C = 1'b0;
    always #5 C = ~C;

    // expected view of all outputs after one clock edge
    typedef struct packed {
        logic [1:0] d;
        logic       ce;
        logic [2:0] level;
        logic       rdy;
        logic       busy;
        logic [7:0] words;
    } exp_t;

    // one output symbol on the line; an activity is a list of symbols
    typedef struct packed {
        logic [1:0] d;
        logic       train;
        logic       last;
    } sym_t;

    exp_t       expq[$];
    logic [3:0] mq[$];
    sym_t       rest[$];
    sym_t       cur;
    bit         pend;
    int         wcnt;
    bit         ready_en;

    function automatic exp_t resetExp();
        exp_t e;
        e = '{d: IP, ce: 1'b0, level: 3'd0, rdy: 1'b0, busy: 1'b0, words: 8'd0};
        return e;
    endfunction

    function automatic exp_t modelOut();
        exp_t e;
        e.d     = cur.d;
        e.ce    = 1'b1;
        e.level = 3'(mq.size());
        e.rdy   = (mq.size() < 4);
        e.busy  = pend || cur.train;
        e.words = 8'(wcnt);
        return e;
    endfunction

    task automatic modelReset();
        mq.delete();
        rest.delete();
        cur      = '{d: IP, train: 1'b0, last: 1'b0};
        pend     = 1'b0;
        wcnt     = 0;
        ready_en = 1'b0;
    endtask

    // One clock edge of the reference: when the current activity runs out,
    // start the next one (training burst, a whole word, or one idle cycle).
    task automatic modelStep(input bit v, input logic [3:0] dat, input bit tr);
        bit         push_ok;
        bit         set_p;
        bit         enter;
        logic [3:0] w;
        push_ok = ready_en && v && (mq.size() < 4);
        set_p   = tr && !cur.train;
        enter   = 1'b0;
        if (cur.last) wcnt = (wcnt + 1) % 256;
        if (rest.size() > 0) begin
            cur = rest.pop_front();
        end else if (pend) begin
            cur = '{d: 2'b10, train: 1'b1, last: 1'b0};
            for (int i = 1; i < TL; i++) rest.push_back('{d: 2'b10, train: 1'b1, last: 1'b0});
            enter = 1'b1;
        end else if (mq.size() > 0) begin
            w   = mq.pop_front();
            cur = '{d: w[3:2], train: 1'b0, last: 1'b0};
            rest.push_back('{d: w[1:0], train: 1'b0, last: 1'b1});
        end else begin
            cur = '{d: IP, train: 1'b0, last: 1'b0};
        end
        if (enter) pend = 1'b0;
        else if (set_p) pend = 1'b1;
        if (push_ok) mq.push_back(dat);
        ready_en = 1'b1;
    endtask

    task automatic checkOutput(input string name, input int actual, input int expected);
        total++;
        if (actual != expected) begin
            bad++;
            $display("[TB] FAIL %s at %0t: got %0d expected %0d", name, $time, actual, expected);
        end
    endtask

    task automatic checkReset();
        checkOutput("rst_d", int'({d1, d2}), int'(IP));
        checkOutput("rst_ce", int'(ce), 0);
        checkOutput("rst_level", int'(level), 0);
        checkOutput("rst_ready", int'(in_ready), 0);
        checkOutput("rst_busy", int'(train_busy), 0);
        checkOutput("rst_words", int'(words_sent), 0);
    endtask

    // drive one cycle of inputs and queue what the next edge should produce
    task automatic applyStimulus(input bit v, input logic [3:0] dat, input bit tr);
        @(negedge C);
        in_valid  = v;
        in_data   = dat;
        train_req = tr;
        if (R) begin
            expq.push_back(resetExp());
        end else begin
            modelStep(v, dat, tr);
            expq.push_back(modelOut());
        end
    endtask

    task automatic releaseReset();
        @(negedge C);
        R         = 1'b0;
        in_valid  = 1'b0;
        train_req = 1'b0;
        modelStep(1'b0, 4'd0, 1'b0);
        expq.push_back(modelOut());
    endtask

    // reset asserted between edges; outputs must clear without a clock
    task automatic pulseReset(input int cycles);
        @(negedge C);
        in_valid  = 1'b0;
        train_req = 1'b0;
        #2;
        R = 1'b1;
        modelReset();
        #1;
        checkReset();
        expq.push_back(resetExp());
        repeat (cycles) applyStimulus(1'b0, 4'd0, 1'b0);
        releaseReset();
    endtask

    task automatic idle(input int n);
        repeat (n) applyStimulus(1'b0, 4'd0, 1'b0);
    endtask

    // monitor: compare every edge's outputs against the oldest expectation
    initial begin
        exp_t e;
        forever begin
            @(posedge C);
            #2;
            if (expq.size() > 0) begin
                e = expq.pop_front();
                checkOutput("d1d2", int'({d1, d2}), int'(e.d));
                checkOutput("ce", int'(ce), int'(e.ce));
                checkOutput("level", int'(level), int'(e.level));
                checkOutput("in_ready", int'(in_ready), int'(e.rdy));
                checkOutput("train_busy", int'(train_busy), int'(e.busy));
                checkOutput("words_sent", int'(words_sent), int'(e.words));
            end
        end
    end

    initial begin
        R         = 1'b1;
        in_valid  = 1'b0;
        in_data   = 4'd0;
        train_req = 1'b0;
        modelReset();
        #1;
        checkReset();
        idle(2);
        releaseReset();
        idle(2);

        // single word
        applyStimulus(1'b1, 4'b1011, 1'b0);
        idle(4);

        // streaming three words back to back
        applyStimulus(1'b1, 4'hA, 1'b0);
        applyStimulus(1'b1, 4'h5, 1'b0);
        applyStimulus(1'b1, 4'hF, 1'b0);
        idle(6);

        // fill FIFO while training holds the scheduler
        applyStimulus(1'b0, 4'd0, 1'b1);
        applyStimulus(1'b1, 4'h1, 1'b0);
        applyStimulus(1'b1, 4'h2, 1'b0);
        applyStimulus(1'b1, 4'h3, 1'b0);
        applyStimulus(1'b1, 4'h4, 1'b0);
        applyStimulus(1'b1, 4'h5, 1'b0);
        idle(TL + 10);

        // training requested during SEND_HI of 4'hC
        applyStimulus(1'b1, 4'hC, 1'b0);
        applyStimulus(1'b0, 4'd0, 1'b0);
        applyStimulus(1'b0, 4'd0, 1'b1);
        idle(TL + 4);

        // reset during SEND_HI with two words queued
        applyStimulus(1'b1, 4'hA, 1'b0);
        applyStimulus(1'b1, 4'hB, 1'b0);
        applyStimulus(1'b1, 4'hC, 1'b0);
        applyStimulus(1'b1, 4'hD, 1'b0);
        pulseReset(2);
        idle(4);

        // randomized traffic with occasional training and reset
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 199) == 0) begin
                pulseReset(int'($urandom_range(1, 3)));
            end else begin
                applyStimulus($urandom_range(0, 99) < 55, 4'($urandom),
                              $urandom_range(0, 99) < 4);
            end
        end
        idle(TL + 10);

        @(posedge C);
        #3;
        checkOutput("queue_drained", expq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
